imm_ext_arbiter: RTL and testbench
==================================

# imm_ext_arbiter

Shares the CPU's single 16-to-32-bit immediate extender between two requesters: the decode stage (port 0) and the branch/jump target unit (port 1). Each request carries a 16-bit immediate and an extension mode; the block arbitrates round-robin, performs the extension, and returns the 32-bit result through a one-entry registered output with valid/ready backpressure. Per-port grant counters support performance debug.

## Interface
- IN_W, 16, immediate input width
- OUT_W, 32, extended result width
- CNT_W, 8, width of each saturating grant counter

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  port 0 request present
- req0_ready  out  1  port 0 request accepted this cycle
- req0_imm  in  IN_W  port 0 immediate
- req0_mode  in  2  port 0 extension mode
- req1_valid / req1_ready / req1_imm / req1_mode  same as port 0, for port 1
- rsp_valid  out  1  result held in output register
- rsp_ready  in  1  consumer takes result this cycle
- rsp_data  out  OUT_W  extended result
- rsp_id  out  1  requester that produced rsp_data (0 or 1)
- grant_cnt0, grant_cnt1  out  CNT_W  accepted-request counts per port

## Operation
- Modes: 00 sign-extend (replicate imm[15] into [31:16]); 01 zero-extend; 10 upper ({imm, 16'h0}); 11 branch offset (sign-extend, then shift left 2, low 2 bits zero).
- Output register FSM, two states:
  - EMPTY: rsp_valid=0. A grant loads the register and moves to FULL.
  - FULL: rsp_valid=1, rsp_data/rsp_id stable. rsp_ready=1 with no grant → EMPTY; rsp_ready=1 with grant → stays FULL with new data (back-to-back); rsp_ready=0 → hold, no grant.
- Slot free = state EMPTY, or FULL with rsp_ready=1.
- Arbitration only when slot free. One valid requester gets the grant. Both valid: the port not granted last wins. last_grant updates only on a grant.
- reqN_ready = slot free and port N wins. Combinational from valid/rsp_ready/state; never asserted when reqN_valid=0.
- Grant counters: +1 on each grant to that port; saturate at 2^CNT_W-1, no wrap.
- Requester inputs are sampled only in the grant cycle; later changes do not affect the held result.

## Timing
- Reset (rst=1 at a clk edge): state EMPTY, rsp_valid=0, rsp_data=0, rsp_id=0, grant counters 0, last_grant=1 (port 0 wins first tie). Reset during FULL discards the held result and ignores requests in that cycle; both ready outputs are 0 while rst=1.
- Latency: grant in cycle N → rsp_valid=1 with result in cycle N+1.
- Throughput: one result per cycle while rsp_ready is held high.
- Backpressure: with FULL and rsp_ready=0, both readies stay 0 and rsp_data/rsp_id are unchanged. This holds for any length of stall.
- Simultaneous valid on both ports with continuous rsp_ready=1: grants alternate 0,1,0,1…
- A requester that is not granted keeps valid asserted and its inputs stable until ready; the block does not check this.

## Test plan
- Modes on port 0, rsp_ready=1: imm 0x47EA mode 00 → 0x000047EA; 0x8001 mode 00 → 0xFFFF8001; 0x8001 mode 01 → 0x00008001; 0x1234 mode 10 → 0x12340000; 0xFFFF mode 11 → 0xFFFFFFFC; 0x0003 mode 11 → 0x0000000C. Each result one cycle after its grant, rsp_id=0.
- Contention: both ports valid for 4 cycles after reset, port0 imm 0x0001, port1 imm 0x0002, mode 00 → rsp_id sequence 0,1,0,1; grant_cnt0=grant_cnt1=2.
- Backpressure: load 0xABCD mode 01, hold rsp_ready=0 for 5 cycles with port 1 valid → rsp_data stays 0x0000ABCD, req1_ready=0 throughout. Raise rsp_ready → port 1 granted that cycle, its result follows next cycle.
- Reset mid-operation: FULL with rsp_ready=0, assert rst one cycle → next cycle rsp_valid=0, counters 0. The first tie after reset goes to port 0.
- Counter saturation: 300 grants to port 0 → grant_cnt0=255, grant_cnt1=0.
- Idle: no valid for 10 cycles → rsp_valid stays 0, readies stay 0, counters unchanged.

Source files
------------

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one 16-to-32-bit immediate extender between two
// requesters, with a one-entry registered result slot and per-port grant counters.
module imm_ext_arbiter #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [IN_W-1:0]  req0_imm,
    input  logic [1:0]       req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [IN_W-1:0]  req1_imm,
    input  logic [1:0]       req1_mode,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [OUT_W-1:0] rsp_data,
    output logic             rsp_id,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    localparam int EXT_W = OUT_W - IN_W;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Extension modes: 00 sign, 01 zero, 10 upper half, 11 sign-extended word offset.
    function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] imm,
                                                    input logic [1:0]      mode);
        logic [OUT_W-1:0] sext;
        logic [OUT_W-1:0] res;
        sext = {{EXT_W{imm[IN_W-1]}}, imm};
        case (mode)
            2'b00:   res = sext;
            2'b01:   res = {{EXT_W{1'b0}}, imm};
            2'b10:   res = {{EXT_W{1'b0}}, imm} << EXT_W;
            2'b11:   res = sext << 2;
            default: res = {OUT_W{1'b0}};
        endcase
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt == {CNT_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    state_t           state_r;
    logic             rsp_valid_r;
    logic [OUT_W-1:0] rsp_data_r;
    logic             rsp_id_r;
    logic             last_grant_r;
    logic [CNT_W-1:0] grant_cnt0_r;
    logic [CNT_W-1:0] grant_cnt1_r;

    logic             slot_free_s;
    logic             win0_s;
    logic             win1_s;
    logic             gnt0_s;
    logic             gnt1_s;
    logic             grant_s;
    logic [IN_W-1:0]  sel_imm_s;
    logic [1:0]       sel_mode_s;
    logic [OUT_W-1:0] ext_s;

    // Slot availability and round-robin winner; readies held low during reset.
    always_comb begin
        slot_free_s = 1'b0;
        win0_s      = 1'b0;
        win1_s      = 1'b0;
        if (state_r == ST_EMPTY) begin
            slot_free_s = 1'b1;
        end else begin
            slot_free_s = rsp_ready;
        end
        // A tie goes to whichever port was not granted most recently.
        if (req0_valid && req1_valid) begin
            win0_s = last_grant_r;
            win1_s = ~last_grant_r;
        end else begin
            win0_s = req0_valid;
            win1_s = req1_valid;
        end
        gnt0_s  = slot_free_s & win0_s & ~rst;
        gnt1_s  = slot_free_s & win1_s & ~rst;
        grant_s = gnt0_s | gnt1_s;
    end

    // Operand mux feeding the single shared extender.
    always_comb begin
        sel_imm_s  = req0_imm;
        sel_mode_s = req0_mode;
        if (gnt1_s) begin
            sel_imm_s  = req1_imm;
            sel_mode_s = req1_mode;
        end else begin
            sel_imm_s  = req0_imm;
            sel_mode_s = req0_mode;
        end
        ext_s = extend_imm(sel_imm_s, sel_mode_s);
    end

    // Output slot FSM with registered result, id and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_EMPTY;
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= {OUT_W{1'b0}};
            rsp_id_r     <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (grant_s) begin
                        state_r      <= ST_FULL;
                        rsp_valid_r  <= 1'b1;
                        rsp_data_r   <= ext_s;
                        rsp_id_r     <= gnt1_s;
                        last_grant_r <= gnt1_s;
                    end else begin
                        state_r     <= ST_EMPTY;
                        rsp_valid_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (grant_s) begin
                        state_r      <= ST_FULL;
                        rsp_valid_r  <= 1'b1;
                        rsp_data_r   <= ext_s;
                        rsp_id_r     <= gnt1_s;
                        last_grant_r <= gnt1_s;
                    end else if (rsp_ready) begin
                        state_r     <= ST_EMPTY;
                        rsp_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_FULL;
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Saturating per-port grant counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0_r <= {CNT_W{1'b0}};
            grant_cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (gnt0_s) begin
                grant_cnt0_r <= sat_inc(grant_cnt0_r);
            end else begin
                grant_cnt0_r <= grant_cnt0_r;
            end
            if (gnt1_s) begin
                grant_cnt1_r <= sat_inc(grant_cnt1_r);
            end else begin
                grant_cnt1_r <= grant_cnt1_r;
            end
        end
    end

    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_data   = rsp_data_r;
    assign rsp_id     = rsp_id_r;
    assign grant_cnt0 = grant_cnt0_r;
    assign grant_cnt1 = grant_cnt1_r;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed, table-driven bench for imm_ext_arbiter: extension modes, contention,
// backpressure, reset mid-operation, counter saturation and idle behaviour.
module tb_imm_ext_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [15:0] req0_imm;
    logic [1:0]  req0_mode;
    logic        req1_valid, req1_ready;
    logic [15:0] req1_imm;
    logic [1:0]  req1_mode;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id;
    logic [7:0]  grant_cnt0, grant_cnt1;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    imm_ext_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_imm   (req0_imm),
        .req0_mode  (req0_mode),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_imm   (req1_imm),
        .req1_mode  (req1_mode),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_imm   = 16'h0000;
        req1_imm   = 16'h0000;
        req0_mode  = 2'b00;
        req1_mode  = 2'b00;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        vecs[0] = '{imm: 16'h47EA, mode: 2'b00, exp: 32'h000047EA};
        vecs[1] = '{imm: 16'h8001, mode: 2'b00, exp: 32'hFFFF8001};
        vecs[2] = '{imm: 16'h8001, mode: 2'b01, exp: 32'h00008001};
        vecs[3] = '{imm: 16'h1234, mode: 2'b10, exp: 32'h12340000};
        vecs[4] = '{imm: 16'hFFFF, mode: 2'b11, exp: 32'hFFFFFFFC};
        vecs[5] = '{imm: 16'h0003, mode: 2'b11, exp: 32'h0000000C};

        idle_inputs();
        rsp_ready = 1'b0;
        rst = 1'b1;
        #2;
        tick();
        tick();
        check("reset_ready0", {31'd0, req0_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("reset_cnt0", {24'd0, grant_cnt0}, 32'd0);
        check("reset_cnt1", {24'd0, grant_cnt1}, 32'd0);

        // Extension modes, back-to-back on port 0.
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_valid = 1'b1;
            req0_imm   = vecs[i].imm;
            req0_mode  = vecs[i].mode;
            #1;
            check("mode_req0_ready", {31'd0, req0_ready}, 32'd1);
            tick();
            req0_imm = 16'h5A5A;
            req0_mode = 2'b01;
            #1;
            check("mode_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("mode_rsp_data", rsp_data, vecs[i].exp);
            check("mode_rsp_id", {31'd0, rsp_id}, 32'd0);
        end
        idle_inputs();

        // Contention: alternate 0,1,0,1 starting with port 0 after reset.
        do_reset();
        req0_valid = 1'b1;
        req0_imm   = 16'h0001;
        req1_valid = 1'b1;
        req1_imm   = 16'h0002;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("cont_rsp_id", {31'd0, rsp_id}, (k % 2 == 0) ? 32'd0 : 32'd1);
            check("cont_rsp_data", rsp_data, (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        idle_inputs();
        #1;
        check("cont_cnt0", {24'd0, grant_cnt0}, 32'd2);
        check("cont_cnt1", {24'd0, grant_cnt1}, 32'd2);

        // Backpressure: held result stays put, port 1 waits.
        do_reset();
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_imm   = 16'hABCD;
        req0_mode  = 2'b01;
        tick();
        idle_inputs();
        req1_valid = 1'b1;
        req1_imm   = 16'h8005;
        req1_mode  = 2'b00;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
            tick();
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_data", rsp_data, 32'h0000ABCD);
            check("bp_rsp_id", {31'd0, rsp_id}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        #1;
        check("bp_p1_data", rsp_data, 32'hFFFF8005);
        check("bp_p1_id", {31'd0, rsp_id}, 32'd1);
        check("bp_cnt1", {24'd0, grant_cnt1}, 32'd1);

        // Reset while FULL and stalled, with a request pending.
        rsp_ready  = 1'b0;
        req1_valid = 1'b1;
        rst        = 1'b1;
        #1;
        check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        rst = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_cnt0", {24'd0, grant_cnt0}, 32'd0);
        check("rst_cnt1", {24'd0, grant_cnt1}, 32'd0);
        rsp_ready  = 1'b1;
        req0_valid = 1'b1;
        req0_imm   = 16'h0011;
        req1_valid = 1'b1;
        req1_imm   = 16'h0022;
        #1;
        check("rst_tie_ready0", {31'd0, req0_ready}, 32'd1);
        check("rst_tie_ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        check("rst_tie_id", {31'd0, rsp_id}, 32'd0);
        idle_inputs();

        // Saturation: 300 grants to port 0.
        do_reset();
        req0_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (k == 254) begin
                check("sat_cnt0_at255", {24'd0, grant_cnt0}, 32'd255);
            end
        end
        idle_inputs();
        #1;
        check("sat_cnt0", {24'd0, grant_cnt0}, 32'd255);
        check("sat_cnt1", {24'd0, grant_cnt1}, 32'd0);

        // Idle: slot drains, then nothing moves for 10 cycles.
        tick();
        for (int k = 0; k < 10; k++) begin
            check("idle_ready0", {31'd0, req0_ready}, 32'd0);
            check("idle_ready1", {31'd0, req1_ready}, 32'd0);
            tick();
            check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        check("idle_cnt0", {24'd0, grant_cnt0}, 32'd255);
        check("idle_cnt1", {24'd0, grant_cnt1}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
